// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Optional macro SERIAL_SUB_OVF_EN adds the signed-overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 4
) (
  input  logic             Clock,
  input  logic             Resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic             br_q, br_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb_q, a_msb_d, b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  logic             accept_s;
  logic             last_s;
  logic             d_bit_s;
  logic             br_next_s;
  logic [WIDTH-1:0] shift_s;

  // Full-subtractor cell and the result register with the new bit in its MSB
  always_comb begin
    d_bit_s   = a_q[0] ^ b_q[0] ^ br_q;
    br_next_s = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
    shift_s   = {d_bit_s, res_q};
    accept_s  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    last_s    = (cnt_q == CW'(WIDTH - 1));
  end

  // Next-state, datapath and output logic
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    br_d    = br_q;
    cnt_d   = cnt_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif
    if (accept_s) begin
      state_d = S_RUN;
      a_d     = a;
      b_d     = b;
      br_d    = bin;
      res_d   = '0;
      cnt_d   = '0;
      busy_d  = 1'b1;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_d = a[WIDTH-1];
      b_msb_d = b[WIDTH-1];
`endif
    end else begin
      case (state_q)
        S_IDLE: state_d = S_IDLE;
        S_RUN: begin
          a_d   = {1'b0, a_q[WIDTH-1:1]};
          b_d   = {1'b0, b_q[WIDTH-1:1]};
          res_d = shift_s[WIDTH-1:1];
          br_d  = br_next_s;
          cnt_d = cnt_q + CW'(1);
          if (last_s) begin
            // Results are published only here, so partial sums never show.
            state_d = S_DONE;
            done_d  = 1'b1;
            diff_d  = shift_s;
            bout_d  = br_next_s;
`ifdef SERIAL_SUB_OVF_EN
            ovf_d   = (a_msb_q ^ b_msb_q) & (a_msb_q ^ d_bit_s);
`endif
          end else begin
            state_d = S_RUN;
            busy_d  = 1'b1;
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      br_q    <= br_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule
